dmem_access: RTL and testbench
==============================

# dmem_access

Memory stage of the rv32 pipeline, directly downstream of the access-control register stage. It consumes that stage's registered instruction, ALU result (effective address), store data and MemRW, runs a single outstanding load/store over a req/ack data-memory port of variable latency, and presents aligned and sign-extended results in a writeback register. A `stall` output freezes the upstream stage while a memory transaction is in flight. Misaligned or illegal accesses and timeouts are reported without a memory access.

## Interface
- `ACK_TIMEOUT`, 16: max cycles `dmem_req` is held without `dmem_ack` before abort (≥2).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_4_acc`  in  32  next-PC value from access stage.
- `alu_out_acc`  in  32  effective address / ALU result.
- `data_b_acc`  in  32  store source data (rs2).
- `instr_acc`  in  32  instruction word.
- `MemRW`  in  1  store-enable from access stage.
- `stall`  out  1  hold upstream inputs stable (combinational).
- `dmem_req`  out  1  memory request, held until ack or timeout.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word-aligned address (`[1:0]`=0).
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rdata`  in  32  read data, valid with ack.
- `dmem_ack`  in  1  one-cycle completion strobe.
- `wb_valid`, `wb_err`  out  1 each  retired instruction / access fault.
- `wb_pc_4`, `wb_alu_out`, `wb_mem_data`, `wb_instr`  out  32 each  writeback payload.

## Operation
- Load: opcode `0000011`, funct3 LB 000, LH 001, LW 010, LBU 100, LHU 101. Store: opcode `0100011` with `MemRW`=1, funct3 SB 000, SH 001, SW 010. Other funct3 = illegal.
- Misaligned: half with `addr[0]`=1, word with `addr[1:0]`≠0.
- Store lanes: SB wdata `{4{b[7:0]}}`, be `0001<<addr[1:0]`; SH `{2{b[15:0]}}`, be `0011<<addr[1:0]`; SW be `1111`.
- Load extract: select byte/half by `addr[1:0]`; LB/LH sign-extend, LBU/LHU zero-extend; LW pass-through.
- FSM `IDLE`, `REQ`:
  - IDLE, non-memory instr: pass through, stall=0, wb regs loaded next edge with `wb_mem_data`=0, `wb_err`=0.
  - IDLE, illegal/misaligned mem op: no request, stall=0, retire next edge with `wb_err`=1, `wb_mem_data`=0.
  - IDLE, legal mem op: stall=1, latch addr/be/wdata/we, clear timeout counter, go REQ.
  - REQ: `dmem_req`=1 from latched regs; stall=1 except in ack or timeout cycle. On ack: capture extracted rdata (stores: 0), `wb_valid`=1, go IDLE. Counter reaching `ACK_TIMEOUT`: drop req, retire with `wb_err`=1, data 0, go IDLE.
- `dmem_ack` in IDLE (late ack) ignored.
- While stalled, `wb_valid` is 0 (bubble); wb payload regs hold.

## Timing
- Non-memory/faulting instr: presented cycle N, `wb_valid` in N+1.
- Memory op: presented N, `dmem_req` rises N+1; ack in cycle M (≥N+1) → `wb_valid` in M+1; upstream advances at end of M.
- Ack in the same cycle as the first req cycle is legal (2-cycle total).
- Reset (asynchronous, any state including REQ): state IDLE, counter 0, `dmem_req`/`dmem_we`/`wb_valid`/`wb_err`=0, `dmem_be`=0, all 32-bit outputs 0; `stall` combinationally 0 until a mem op is presented after release.
- Simultaneous ack and timeout terminal count: ack wins, no error.

## Structure
- Shared package `rv32_pkg`: opcode constants (LOAD, STORE), load/store funct3 constants, `dmem_state_t` enum.
- Sub-module `lsu_align` (combinational): funct3 + addr[1:0] + store data/read data → be, wdata, extracted load data, misalign/illegal flags.

## Test plan
- ADD-class instr, alu_out 0x1234 → no req, stall 0, next cycle wb_valid=1, wb_alu_out=0x1234, wb_mem_data=0.
- SB addr 0x103, data_b 0xA5 → dmem_addr 0x100, be 1000, wdata 0xA5A5A5A5, we=1; ack after 3 cycles → stall 3 cycles+, wb_valid one cycle after ack.
- LB addr 0x102, rdata 0x00800000 → wb_mem_data 0xFFFFFF80; LBU same → 0x00000080; LH addr 0x102, rdata 0x80010000 → 0xFFFF8001.
- SW addr 0x202 → no req, wb_err=1 next cycle; funct3 011 load → same.
- LW with no ack → req held exactly ACK_TIMEOUT cycles, then wb_err=1, data 0; late ack afterward ignored.
- rst_n low during REQ → dmem_req, stall, wb_valid drop immediately; after release next LW (ack same cycle as req) retires 2 cycles after presentation.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: constants and types shared by the rv32 memory stage.
//   - major opcodes for loads and stores
//   - load/store funct3 encodings
//   - dmem_state_t: state of the single-outstanding memory access FSM
package rv32_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for loads and stores.
// Ports:
//   is_load, is_store  in   access class being decoded
//   funct3             in   access width / signedness
//   addr_lo            in   effective address [1:0]
//   store_data         in   rs2 value for stores
//   rdata              in   raw 32-bit word returned by memory
//   be                 out  byte enables for the access
//   wdata              out  lane-replicated store data
//   load_data          out  extracted, sign/zero-extended load result
//   misaligned         out  width not naturally aligned to addr_lo
//   illegal            out  funct3 not a valid encoding for the class
module lsu_align
    import rv32_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0;
        load_data  = 32'h0;
        misaligned = 1'b0;
        illegal    = 1'b0;

        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                F3_SH: begin
                    be         = 4'b0011 << addr_lo;
                    wdata      = {2{store_data[15:0]}};
                    misaligned = addr_lo[0];
                end
                F3_SW: begin
                    be         = 4'b1111;
                    wdata      = store_data;
                    misaligned = |addr_lo;
                end
                default: illegal = 1'b1;
            endcase
        end else if (is_load) begin
            case (funct3)
                F3_LB: begin
                    be        = 4'b0001 << addr_lo;
                    load_data = {{24{rbyte[7]}}, rbyte};
                end
                F3_LBU: begin
                    be        = 4'b0001 << addr_lo;
                    load_data = {24'h0, rbyte};
                end
                F3_LH: begin
                    be         = 4'b0011 << addr_lo;
                    load_data  = {{16{rhalf[15]}}, rhalf};
                    misaligned = addr_lo[0];
                end
                F3_LHU: begin
                    be         = 4'b0011 << addr_lo;
                    load_data  = {16'h0, rhalf};
                    misaligned = addr_lo[0];
                end
                F3_LW: begin
                    be         = 4'b1111;
                    load_data  = rdata;
                    misaligned = |addr_lo;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_access.sv
// dmem_access: rv32 memory stage. Runs one outstanding load/store over a
// req/ack data-memory port and presents results in a writeback register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   pc_4_acc, alu_out_acc,
//   data_b_acc, instr_acc, MemRW    registered inputs from the access stage
//   stall                           freeze upstream while an access is in flight
//   dmem_req/we/addr/be/wdata       memory request (held until ack or timeout)
//   dmem_rdata, dmem_ack            memory response, rdata valid with ack
//   wb_valid, wb_err                retired instruction / access fault
//   wb_pc_4, wb_alu_out,
//   wb_mem_data, wb_instr           writeback payload
module dmem_access
    import rv32_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_4_acc,
    input  logic [31:0] alu_out_acc,
    input  logic [31:0] data_b_acc,
    input  logic [31:0] instr_acc,
    input  logic        MemRW,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_err,
    output logic [31:0] wb_pc_4,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_instr
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    dmem_state_t state;
    logic [CW-1:0] cnt;

    // Access attributes captured at launch so load extraction does not
    // depend on the upstream registers during the wait.
    logic [2:0] f3_q;
    logic [1:0] lo_q;
    logic       ld_q;

    logic       is_load, is_store, in_req;
    logic [2:0] a_f3;
    logic [1:0] a_lo;
    logic       a_ld, a_st;
    logic [3:0] a_be;
    logic [31:0] a_wdata, a_ldata;
    logic       a_mis, a_ill;
    logic       legal_mem, fault, timeout;

    assign is_load  = (instr_acc[6:0] == OP_LOAD);
    assign is_store = (instr_acc[6:0] == OP_STORE) && MemRW;
    assign in_req   = (state == REQ);

    // In IDLE the aligner decodes the presented instruction; in REQ it
    // extracts read data using the attributes latched at launch.
    assign a_f3 = in_req ? f3_q : instr_acc[14:12];
    assign a_lo = in_req ? lo_q : alu_out_acc[1:0];
    assign a_ld = in_req ? ld_q : is_load;
    assign a_st = in_req ? 1'b0 : is_store;

    lsu_align u_align (
        .is_load    (a_ld),
        .is_store   (a_st),
        .funct3     (a_f3),
        .addr_lo    (a_lo),
        .store_data (data_b_acc),
        .rdata      (dmem_rdata),
        .be         (a_be),
        .wdata      (a_wdata),
        .load_data  (a_ldata),
        .misaligned (a_mis),
        .illegal    (a_ill)
    );

    assign legal_mem = (is_load || is_store) && !a_mis && !a_ill;
    assign fault     = (is_load || is_store) && (a_mis || a_ill);
    assign timeout   = in_req && (cnt == CW'(ACK_TIMEOUT - 1));

    // Gated by rst_n so upstream is released as soon as reset asserts,
    // even if a memory op is still sitting on the inputs.
    assign stall = rst_n && ((!in_req && legal_mem) ||
                             (in_req && !dmem_ack && !timeout));

    assign dmem_req = in_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= 3'b0;
            lo_q        <= 2'b0;
            ld_q        <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'h0;
            dmem_be     <= 4'b0;
            dmem_wdata  <= 32'h0;
            wb_valid    <= 1'b0;
            wb_err      <= 1'b0;
            wb_pc_4     <= 32'h0;
            wb_alu_out  <= 32'h0;
            wb_mem_data <= 32'h0;
            wb_instr    <= 32'h0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal_mem) begin
                        dmem_addr  <= {alu_out_acc[31:2], 2'b00};
                        dmem_be    <= a_be;
                        dmem_wdata <= a_wdata;
                        dmem_we    <= is_store;
                        f3_q       <= instr_acc[14:12];
                        lo_q       <= alu_out_acc[1:0];
                        ld_q       <= is_load;
                        cnt        <= '0;
                        state      <= REQ;
                    end else begin
                        // Non-memory op or faulting access retires directly.
                        wb_valid    <= 1'b1;
                        wb_err      <= fault;
                        wb_mem_data <= 32'h0;
                        wb_pc_4     <= pc_4_acc;
                        wb_alu_out  <= alu_out_acc;
                        wb_instr    <= instr_acc;
                    end
                end
                REQ: begin
                    if (dmem_ack || timeout) begin
                        // Ack takes priority over a coincident terminal count.
                        wb_valid    <= 1'b1;
                        wb_err      <= !dmem_ack;
                        wb_mem_data <= (dmem_ack && ld_q) ? a_ldata : 32'h0;
                        wb_pc_4     <= pc_4_acc;
                        wb_alu_out  <= alu_out_acc;
                        wb_instr    <= instr_acc;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed stimulus with a scoreboard. The stimulus pushes
// the expected retirement (payload, error, data, retire cycle) for each
// instruction; a monitor pops and compares whenever wb_valid is seen.
// Filler NOPs presented between directed phases are not scoreboarded.
module tb_dmem_access;

    localparam int T = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [31:0] I_ADD  = 32'h00B5_0533;
    localparam logic [31:0] I_LB   = 32'h0000_0003;
    localparam logic [31:0] I_LH   = 32'h0000_1003;
    localparam logic [31:0] I_LW   = 32'h0000_2003;
    localparam logic [31:0] I_L011 = 32'h0000_3003;
    localparam logic [31:0] I_LBU  = 32'h0000_4003;
    localparam logic [31:0] I_LHU  = 32'h0000_5003;
    localparam logic [31:0] I_SB   = 32'h0000_0023;
    localparam logic [31:0] I_SH   = 32'h0000_1023;
    localparam logic [31:0] I_SW   = 32'h0000_2023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_4_acc, alu_out_acc, data_b_acc, instr_acc;
    logic        MemRW;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        wb_valid, wb_err;
    logic [31:0] wb_pc_4, wb_alu_out, wb_mem_data, wb_instr;

    dmem_access #(.ACK_TIMEOUT(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_4_acc    (pc_4_acc),
        .alu_out_acc (alu_out_acc),
        .data_b_acc  (data_b_acc),
        .instr_acc   (instr_acc),
        .MemRW       (MemRW),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .wb_valid    (wb_valid),
        .wb_err      (wb_err),
        .wb_pc_4     (wb_pc_4),
        .wb_alu_out  (wb_alu_out),
        .wb_mem_data (wb_mem_data),
        .wb_instr    (wb_instr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int passed = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    endtask

    // Monitor: compare each retirement against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_instr !== NOP) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_retire: got instr 0x%08h, required none", wb_instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_instr", wb_instr, e.instr);
                check("wb_err", {31'b0, wb_err}, {31'b0, e.err});
                check("wb_mem_data", wb_mem_data, e.data);
                check("wb_alu_out", wb_alu_out, e.alu);
                check("wb_pc_4", wb_pc_4, e.pc4);
                check("retire_cycle", cyc, e.cyc);
            end
        end
    end

    // ack_dly: -1 no request expected, 0 expect timeout, d>0 ack in d-th req cycle.
    task automatic do_op(input string nm, input logic [31:0] instr, input logic [31:0] addr,
                         input logic [31:0] b, input logic memrw, input int ack_dly,
                         input logic [31:0] rdata, input logic exp_err, input logic [31:0] exp_data,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic late_ack);
        exp_t e;
        int lat;
        int n;
        logic [31:0] pc;
        @(posedge clk); #1;
        dmem_ack    = late_ack;
        dmem_rdata  = late_ack ? 32'hFFFF_FFFF : 32'h0;
        pc          = addr ^ 32'h5A5A_0000;
        instr_acc   = instr;
        alu_out_acc = addr;
        data_b_acc  = b;
        MemRW       = memrw;
        pc_4_acc    = pc;
        lat = (ack_dly < 0) ? 1 : ((ack_dly == 0) ? T + 1 : ack_dly + 1);
        e = '{instr, addr, pc, exp_data, exp_err, cyc + lat};
        sb.push_back(e);
        #1;
        if (ack_dly < 0) begin
            check({nm, "_stall"}, {31'b0, stall}, 32'd0);
            check({nm, "_req"}, {31'b0, dmem_req}, 32'd0);
        end else begin
            check({nm, "_stall0"}, {31'b0, stall}, 32'd1);
            n = 0;
            for (int k = 1; k <= T + 4; k++) begin
                @(posedge clk); #1;
                if (!dmem_req) break;
                n++;
                if (k == 1) begin
                    check({nm, "_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
                    check({nm, "_we"}, {31'b0, dmem_we}, {31'b0, memrw});
                    if (memrw) begin
                        check({nm, "_be"}, {28'b0, dmem_be}, {28'b0, exp_be});
                        check({nm, "_wdata"}, dmem_wdata, exp_wdata);
                    end
                end
                if (k == ack_dly) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                    #1;
                    check({nm, "_stall_ack"}, {31'b0, stall}, 32'd0);
                    break;
                end
                if (ack_dly > 0) check({nm, "_stall_wait"}, {31'b0, stall}, 32'd1);
                if (ack_dly == 0 && !stall) break;
            end
            check({nm, "_req_cycles"}, n, (ack_dly == 0) ? T : ack_dly);
        end
    endtask

    initial begin
        instr_acc   = NOP;
        alu_out_acc = 32'h0;
        data_b_acc  = 32'h0;
        pc_4_acc    = 32'h0;
        MemRW       = 1'b0;
        dmem_ack    = 1'b0;
        dmem_rdata  = 32'h0;

        #12;
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_err", {31'b0, wb_err}, 32'd0);
        check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        check("rst_dmem_be", {28'b0, dmem_be}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_wb_alu_out", wb_alu_out, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_op("add",   I_ADD, 32'h1234, 32'h0,        1'b0, -1, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b0);
        do_op("sb",    I_SB,  32'h103,  32'hA5,       1'b1,  3, 32'h0,        1'b0, 32'h0,        4'b1000, 32'hA5A5A5A5, 1'b0);
        do_op("lb",    I_LB,  32'h102,  32'h0,        1'b0,  1, 32'h00800000, 1'b0, 32'hFFFFFF80, 4'h0,    32'h0,        1'b0);
        do_op("lbu",   I_LBU, 32'h102,  32'h0,        1'b0,  2, 32'h00800000, 1'b0, 32'h00000080, 4'h0,    32'h0,        1'b0);
        do_op("lh",    I_LH,  32'h102,  32'h0,        1'b0,  1, 32'h80010000, 1'b0, 32'hFFFF8001, 4'h0,    32'h0,        1'b0);
        do_op("lhu",   I_LHU, 32'h102,  32'h0,        1'b0,  1, 32'h80010000, 1'b0, 32'h00008001, 4'h0,    32'h0,        1'b0);
        do_op("lw",    I_LW,  32'h104,  32'h0,        1'b0,  4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'h0,    32'h0,        1'b0);
        do_op("sh",    I_SH,  32'h106,  32'h1234BEEF, 1'b1,  2, 32'h0,        1'b0, 32'h0,        4'b1100, 32'hBEEFBEEF, 1'b0);
        do_op("sw",    I_SW,  32'h200,  32'hCAFEF00D, 1'b1,  1, 32'h0,        1'b0, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0);
        do_op("sw_mis",I_SW,  32'h202,  32'h1,        1'b1, -1, 32'h0,        1'b1, 32'h0,        4'h0,    32'h0,        1'b0);
        do_op("ld011", I_L011,32'h100,  32'h0,        1'b0, -1, 32'h0,        1'b1, 32'h0,        4'h0,    32'h0,        1'b0);
        do_op("lh_mis",I_LH,  32'h101,  32'h0,        1'b0, -1, 32'h0,        1'b1, 32'h0,        4'h0,    32'h0,        1'b0);
        do_op("st_norw",I_SB, 32'h108,  32'h77,       1'b0, -1, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b0);
        do_op("lw_to", I_LW,  32'h300,  32'h0,        1'b0,  0, 32'h0,        1'b1, 32'h0,        4'h0,    32'h0,        1'b0);
        do_op("late",  I_ADD, 32'h55,   32'h0,        1'b0, -1, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b1);

        // Reset while a load is waiting for its ack.
        @(posedge clk); #1;
        dmem_ack    = 1'b0;
        instr_acc   = I_LW;
        alu_out_acc = 32'h400;
        MemRW       = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_req", {31'b0, dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("in_rst_req", {31'b0, dmem_req}, 32'd0);
        check("in_rst_stall", {31'b0, stall}, 32'd0);
        check("in_rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("in_rst_we", {31'b0, dmem_we}, 32'd0);
        sb.delete();
        instr_acc = NOP;
        @(negedge clk) rst_n = 1'b1;

        do_op("lw_fast", I_LW, 32'h404, 32'h0, 1'b0, 1, 32'h11223344, 1'b0, 32'h11223344, 4'h0, 32'h0, 1'b0);

        @(posedge clk); #1;
        dmem_ack  = 1'b0;
        instr_acc = NOP;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
